iobus_timer: RTL
================

# iobus_timer

Memory-mapped down-counting timer that sits on the MCU's IOBUS as a responder. It decodes IOBUS writes into its control registers and returns register contents on IOBUS reads. It drives the MCU's `INTR` input when a programmed interval expires. It gives the pipelined core a periodic or one-shot interrupt source without software polling.

## Interface
Parameters:
- `BASE_ADDR`, default 32'h1100_0100: word-aligned base of the 32-byte register window.
- `PRESCALE_W`, default 16: width of the prescaler register.

Ports:
- `CLK`, in, 1: system clock. All state changes on the rising edge.
- `RESET`, in, 1: reset, asynchronous and active-high.
- `IOBUS_ADDR`, in, 32: byte address from the MCU.
- `IOBUS_OUT`, in, 32: write data from the MCU.
- `IOBUS_WR`, in, 1: write strobe, one cycle per store.
- `RD_DATA`, out, 32: read data, routed to the MCU `IOBUS_IN` through the top-level mux.
- `RD_HIT`, out, 1: high when `IOBUS_ADDR` selects a defined register. Used as the top-level mux select.
- `INTR`, out, 1: interrupt request to the MCU.

## Operation
Register map (byte offsets from `BASE_ADDR`):
- 0x00 CTRL (rw): bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN. Bits 31:3 read 0.
- 0x04 PRESCALE (rw): width `PRESCALE_W`, zero-extended on read.
- 0x08 LOAD (rw): 32-bit interval value.
- 0x0C COUNT (ro): current count. Writes are ignored.
- 0x10 STATUS: bit0 EXPIRED, sticky. Writing 1 to bit0 clears it; writing 0 has no effect.

Address decode:
- Only word-aligned offsets 0x00–0x10 hit.
- Any other address gives `RD_HIT`=0 and `RD_DATA`=0, and writes to it are ignored.
- Reads are combinational from the registers.

State machine (IDLE, RUN, DONE):
- Any state, write CTRL with EN=1 while the current EN=0: COUNT←LOAD, prescaler←0, go to RUN.
- Any state, write CTRL with EN=0: go to IDLE. COUNT holds; EXPIRED is unchanged.
- Write CTRL with EN=1 while already EN=1: only the AUTO_RELOAD and IRQ_EN bits update. No restart.
- RUN, on each prescaler tick:
  - If COUNT≠0, decrement COUNT.
  - If COUNT==0, set EXPIRED. With AUTO_RELOAD=1, COUNT←LOAD and stay in RUN. Otherwise go to DONE.
- DONE holds COUNT=0 until CTRL is rewritten.

Prescaler:
- Counts 0..PRESCALE.
- Tick is high in the cycle where prescaler==PRESCALE; the prescaler then wraps to 0.
- PRESCALE=0 gives a tick every cycle.
- Runs only in RUN.

Interrupt:
- `INTR` = EXPIRED & IRQ_EN, combinational from registered state (glitch-free).
- `INTR` stays high until software clears EXPIRED or IRQ_EN.

## Timing
Reset values:
- CTRL=0, PRESCALE=0, LOAD=0, COUNT=0, EXPIRED=0, prescaler=0, state IDLE.
- Outputs: `INTR`=0. `RD_DATA` and `RD_HIT` follow the address decode of these reset values.

Write timing:
- Writes take effect at the `CLK` edge where `IOBUS_WR`=1.

Expiry latency:
- With PRESCALE=P and LOAD=N, EXPIRED is set at the edge (N+1)·(P+1) cycles after the enabling write edge.
- `INTR` rises right after that edge.
- In auto-reload mode the period is (N+1)·(P+1).
- LOAD=0 expires on every tick.

Boundary cases:
- A LOAD write during RUN does not change COUNT; it is used at the next reload or enable.
- A PRESCALE write takes effect immediately. If the prescaler value already exceeds the new PRESCALE, it continues to 2^PRESCALE_W−1, wraps to 0, then proceeds normally.
- EXPIRED set and a W1C clear in the same cycle: set wins.
- Async `RESET` mid-RUN returns every register to its reset value immediately; `INTR` drops with no clock edge needed.

## Structure
- Package `iobus_timer_pkg`: register offset constants, CTRL bit index constants, and the state enum `timer_state_t` {IDLE, RUN, DONE}.
- Sub-module `iobus_prescaler`: parameter `PRESCALE_W`; ports clk, reset, clear, enable, limit; output tick.
- Top level `iobus_timer`: address decode, register file, state machine, read mux.

## Test plan
- Reset, then read all five offsets: each returns 0 with `RD_HIT`=1. Reading offset 0x14 gives `RD_HIT`=0 and `RD_DATA`=0.
- PRESCALE=0, LOAD=3, write CTRL=0x5: EXPIRED and `INTR` go high exactly 4 cycles after the CTRL write edge. The state then holds DONE with COUNT=0.
- PRESCALE=1, LOAD=2, CTRL=0x3 (auto-reload, IRQ_EN=0): EXPIRED sets at cycle 6 and COUNT reloads to 2. `INTR` stays 0 throughout. Clearing EXPIRED, it re-sets at cycle 12.
- Auto-reload with LOAD=0 and PRESCALE=0: EXPIRED sets every cycle. A W1C to STATUS in an expiring cycle leaves EXPIRED=1.
- Mid-RUN with COUNT=5, write LOAD=9: COUNT continues 4,3,… and reloads 9 after expiry. A write to COUNT changes nothing.
- Assert `RESET` asynchronously mid-RUN while `INTR`=1: `INTR`=0 and all registers read 0 before the next `CLK` edge. After release, the timer stays IDLE.

Source files
------------

// File: rtl/iobus_timer_pkg.sv
// Shared constants and types for the IOBUS down-counting timer.
package iobus_timer_pkg;

  localparam logic [31:0] OFF_CTRL     = 32'h00;
  localparam logic [31:0] OFF_PRESCALE = 32'h04;
  localparam logic [31:0] OFF_LOAD     = 32'h08;
  localparam logic [31:0] OFF_COUNT    = 32'h0C;
  localparam logic [31:0] OFF_STATUS   = 32'h10;

  localparam int unsigned CTRL_EN   = 0;
  localparam int unsigned CTRL_AUTO = 1;
  localparam int unsigned CTRL_IRQ  = 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } timer_state_t;

endpackage

// File: rtl/iobus_prescaler.sv
// Free-running prescaler: counts 0..limit while enabled, tick marks the terminal cycle.
module iobus_prescaler #(
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] limit,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] r_cnt;

  assign tick = enable && (r_cnt == limit);

  // A count already past a freshly lowered limit runs on to all-ones and wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= tick ? '0 : r_cnt + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/iobus_timer.sv
// IOBUS responder timer: register file, address decode, run-state machine and interrupt.
module iobus_timer
  import iobus_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h1100_0100,
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] RD_DATA,
  output logic        RD_HIT,
  output logic        INTR
);

  logic [2:0]            r_ctrl;
  logic [PRESCALE_W-1:0] r_prescale;
  logic [31:0]           r_load;
  logic [31:0]           r_count;
  logic                  r_expired;
  timer_state_t          r_state;

  logic [31:0] w_off;
  logic        w_hit;
  logic        w_wr_ctrl;
  logic        w_wr_status;
  logic        w_start;
  logic        w_stop;
  logic        w_tick;

  // Subtracting the base tolerates any word-aligned base, not just 32-byte aligned ones.
  assign w_off       = IOBUS_ADDR - BASE_ADDR;
  assign w_hit       = (w_off[1:0] == 2'b00) && (w_off <= OFF_STATUS);
  assign w_wr_ctrl   = IOBUS_WR && w_hit && (w_off == OFF_CTRL);
  assign w_wr_status = IOBUS_WR && w_hit && (w_off == OFF_STATUS);
  assign w_start     = w_wr_ctrl && IOBUS_OUT[CTRL_EN] && !r_ctrl[CTRL_EN];
  assign w_stop      = w_wr_ctrl && !IOBUS_OUT[CTRL_EN];

  iobus_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .clk   (CLK),
    .reset (RESET),
    .clear (w_start),
    .enable(r_state == RUN),
    .limit (r_prescale),
    .tick  (w_tick)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_ctrl     <= '0;
      r_prescale <= '0;
      r_load     <= '0;
    end else if (IOBUS_WR && w_hit) begin
      if (w_off == OFF_CTRL)     r_ctrl     <= IOBUS_OUT[2:0];
      if (w_off == OFF_PRESCALE) r_prescale <= IOBUS_OUT[PRESCALE_W-1:0];
      if (w_off == OFF_LOAD)     r_load     <= IOBUS_OUT;
    end
  end

  // The expiry set is assigned after the W1C clear so a coincident set wins.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_expired <= 1'b0;
    end else begin
      if (w_wr_status && IOBUS_OUT[0]) r_expired <= 1'b0;
      if (w_start) begin
        r_state <= RUN;
        r_count <= r_load;
      end else if (w_stop) begin
        r_state <= IDLE;
      end else if ((r_state == RUN) && w_tick) begin
        if (r_count != 32'd0) begin
          r_count <= r_count - 32'd1;
        end else begin
          r_expired <= 1'b1;
          if (r_ctrl[CTRL_AUTO]) r_count <= r_load;
          else                   r_state <= DONE;
        end
      end
    end
  end

  always_comb begin
    RD_DATA = '0;
    unique case (w_off)
      OFF_CTRL:     RD_DATA = {29'b0, r_ctrl};
      OFF_PRESCALE: RD_DATA = 32'(r_prescale);
      OFF_LOAD:     RD_DATA = r_load;
      OFF_COUNT:    RD_DATA = r_count;
      OFF_STATUS:   RD_DATA = {31'b0, r_expired};
      default:      RD_DATA = '0;
    endcase
  end

  assign RD_HIT = w_hit;
  assign INTR   = r_expired & r_ctrl[CTRL_IRQ];

endmodule
